// File: rtl/serial_wb_master.sv
// -----------------------------------------------------------------------------
// serial_wb_master
//
// Turns a byte-oriented command stream from a UART into single bus cycles.
//   'w' <adr> <dat>  -> bus write; answers ACK_CHAR, or NAK_CHAR on timeout
//   'r' <adr>        -> bus read;  answers the read byte, or 8'hFF on timeout
// Unknown opcodes are silently dropped.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   uart_data_i[7:0]      UART read data (adr 0: RX byte, adr 1: {tx_idle, rx_avail})
//   uart_data_o[7:0]      UART TX byte
//   uart_address_o        UART register select
//   uart_writestrobe_o    one-cycle TX write strobe
//   uart_readstrobe_o     one-cycle strobe (at adr 1) that clears rx_avail
//   wb_adr_o, wb_dat_o    bus address / write data (held between commands)
//   wb_dat_i              bus read data
//   wb_we_o, wb_cyc_o,
//   wb_stb_o, wb_ack_i    bus handshake
// -----------------------------------------------------------------------------
module serial_wb_master #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [7:0]  ACK_CHAR = 8'h2E,
    parameter logic [7:0]  NAK_CHAR = 8'h21
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] uart_data_i,
    output logic [7:0] uart_data_o,
    output logic       uart_address_o,
    output logic       uart_writestrobe_o,
    output logic       uart_readstrobe_o,
    output logic [7:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    input  logic       wb_ack_i
);

    typedef enum logic [2:0] {
        RXWAIT,
        RXGRAB,
        RXCLR,
        PARSE,
        BUS,
        TXWAIT,
        TXSEND
    } state_e;

    localparam logic [7:0] OP_WRITE = 8'h77;
    localparam logic [7:0] OP_READ  = 8'h72;
    // Counter value seen in the last permitted wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e     state_q;
    logic [1:0] idx_q;        // which command byte PARSE is looking at
    logic       is_write_q;
    logic [7:0] byte_q;       // last byte pulled from the UART
    logic [7:0] resp_q;       // byte to send back once the bus cycle ends
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    // Saturating increment: the counter must never wrap back to zero.
    assign wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

    // Outputs are registers written together with the state transition, so each
    // output value already matches the state being entered.
    always_ff @(posedge clk_i) begin
        // NOTE: all state here uses non-blocking assignment so every branch sees
        // the pre-edge values; the synchronous reset is just the first branch.
        if (rst_i) begin
            state_q            <= RXWAIT;
            idx_q              <= 2'd0;
            is_write_q         <= 1'b0;
            byte_q             <= 8'h00;
            resp_q             <= 8'h00;
            wait_cnt_q         <= 8'h00;
            uart_data_o        <= 8'h00;
            uart_address_o     <= 1'b1;
            uart_writestrobe_o <= 1'b0;
            uart_readstrobe_o  <= 1'b0;
            wb_adr_o           <= 8'h00;
            wb_dat_o           <= 8'h00;
            wb_we_o            <= 1'b0;
            wb_cyc_o           <= 1'b0;
            wb_stb_o           <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a branch below sets them.
            uart_writestrobe_o <= 1'b0;
            uart_readstrobe_o  <= 1'b0;

            case (state_q)
                RXWAIT: begin
                    if (uart_data_i[0]) begin
                        state_q        <= RXGRAB;
                        uart_address_o <= 1'b0;
                    end
                end

                RXGRAB: begin
                    byte_q            <= uart_data_i;
                    state_q           <= RXCLR;
                    uart_address_o    <= 1'b1;
                    uart_readstrobe_o <= 1'b1;
                end

                RXCLR: begin
                    state_q <= PARSE;
                end

                PARSE: begin
                    case (idx_q)
                        2'd0: begin
                            if (byte_q == OP_WRITE || byte_q == OP_READ) begin
                                is_write_q <= (byte_q == OP_WRITE);
                                idx_q      <= 2'd1;
                            end
                            state_q <= RXWAIT;
                        end
                        2'd1: begin
                            wb_adr_o <= byte_q;
                            if (is_write_q) begin
                                idx_q   <= 2'd2;
                                state_q <= RXWAIT;
                            end else begin
                                state_q    <= BUS;
                                wait_cnt_q <= 8'h00;
                                wb_cyc_o   <= 1'b1;
                                wb_stb_o   <= 1'b1;
                                wb_we_o    <= 1'b0;
                            end
                        end
                        default: begin
                            wb_dat_o   <= byte_q;
                            state_q    <= BUS;
                            wait_cnt_q <= 8'h00;
                            wb_cyc_o   <= 1'b1;
                            wb_stb_o   <= 1'b1;
                            wb_we_o    <= 1'b1;
                        end
                    endcase
                end

                BUS: begin
                    // Ack is tested before the timeout so an ack in the last
                    // permitted cycle still counts as success.
                    if (wb_ack_i) begin
                        resp_q   <= is_write_q ? ACK_CHAR : wb_dat_i;
                        state_q  <= TXWAIT;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        resp_q   <= is_write_q ? NAK_CHAR : 8'hFF;
                        state_q  <= TXWAIT;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end

                TXWAIT: begin
                    // Unbounded wait for the transmitter to go idle.
                    if (uart_data_i[1]) begin
                        state_q            <= TXSEND;
                        uart_address_o     <= 1'b0;
                        uart_data_o        <= resp_q;
                        uart_writestrobe_o <= 1'b1;
                    end
                end

                TXSEND: begin
                    state_q        <= RXWAIT;
                    uart_address_o <= 1'b1;
                    idx_q          <= 2'd0;
                end

                default: begin
                    state_q        <= RXWAIT;
                    uart_address_o <= 1'b1;
                    idx_q          <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_wb_master.sv
// -----------------------------------------------------------------------------
// tb_serial_wb_master
//
// Bench for serial_wb_master. A small UART model feeds queued RX bytes and
// records TX bytes; a bus slave model acks after a programmable number of
// strobe cycles. A table of command vectors is run in a loop, followed by
// hand-written sequences for TX back-pressure and reset during a bus cycle.
// -----------------------------------------------------------------------------
module tb_serial_wb_master;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] uart_data_i;
    logic [7:0] uart_data_o;
    logic       uart_address_o;
    logic       uart_writestrobe_o;
    logic       uart_readstrobe_o;
    logic [7:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_ack_i;

    always #5 clk_i = ~clk_i;

    serial_wb_master dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .uart_data_i        (uart_data_i),
        .uart_data_o        (uart_data_o),
        .uart_address_o     (uart_address_o),
        .uart_writestrobe_o (uart_writestrobe_o),
        .uart_readstrobe_o  (uart_readstrobe_o),
        .wb_adr_o           (wb_adr_o),
        .wb_dat_o           (wb_dat_o),
        .wb_dat_i           (wb_dat_i),
        .wb_we_o            (wb_we_o),
        .wb_cyc_o           (wb_cyc_o),
        .wb_stb_o           (wb_stb_o),
        .wb_ack_i           (wb_ack_i)
    );

    // ---------------- UART model ----------------
    logic [7:0] rx_mem [64];
    int         rx_wr = 0;      // written by the stimulus process only
    int         rx_rd = 0;      // written by the model process only
    logic       tx_idle = 1'b1;
    logic       rx_avail;
    int         n_tx = 0;
    logic [7:0] last_tx = 8'h00;

    assign rx_avail    = (rx_rd != rx_wr);
    assign uart_data_i = uart_address_o ? {6'b0, tx_idle, rx_avail} : rx_mem[rx_rd[5:0]];

    always @(posedge clk_i) begin
        if (uart_readstrobe_o && uart_address_o && rx_avail)
            rx_rd <= rx_rd + 1;
        if (uart_writestrobe_o && !uart_address_o) begin
            n_tx    <= n_tx + 1;
            last_tx <= uart_data_o;
        end
    end

    // ---------------- bus slave model ----------------
    bit         ack_en  = 1'b1;
    int         ack_dly = 0;
    logic [7:0] rd_data = 8'h00;
    int         stb_cnt = 0;

    assign wb_dat_i = rd_data;
    assign wb_ack_i = ack_en && wb_stb_o && (stb_cnt == ack_dly);

    always @(posedge clk_i) begin
        if (!wb_stb_o)      stb_cnt <= 0;
        else if (!wb_ack_i) stb_cnt <= stb_cnt + 1;
    end

    // ---------------- bus monitor ----------------
    int         n_bus   = 0;
    int         cur_len = 0;
    int         stb_len = 0;
    logic       prev_stb = 1'b0;
    logic [7:0] cap_adr = 8'h00;
    logic [7:0] cap_dat = 8'h00;
    logic       cap_we  = 1'b0;

    always @(posedge clk_i) begin
        prev_stb <= wb_stb_o;
        if (wb_stb_o) begin
            if (!prev_stb) begin
                n_bus   <= n_bus + 1;
                cur_len <= 1;
                cap_adr <= wb_adr_o;
                cap_dat <= wb_dat_o;
                cap_we  <= wb_we_o;
            end else begin
                cur_len <= cur_len + 1;
            end
        end else if (prev_stb) begin
            stb_len <= cur_len;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[rx_wr[5:0]] = b;
        rx_wr = rx_wr + 1;
    endtask

    task automatic wait_tx(input string name, input int start);
        int k;
        k = 0;
        while (n_tx == start && k < 2000) begin
            @(negedge clk_i);
            k++;
        end
        if (n_tx == start) check({name, " tx timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0] b [3];
        int         nb;
        bit         ack_en;
        int         ack_dly;
        logic [7:0] rdat;
        logic [7:0] e_adr;
        logic [7:0] e_dat;
        logic       e_we;
        int         e_len;
        logic [7:0] e_tx;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input int nb, input bit aen, input int adly, input logic [7:0] rdat,
                                input logic [7:0] eadr, input logic [7:0] edat, input logic ewe,
                                input int elen, input logic [7:0] etx);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.nb = nb; v.ack_en = aen; v.ack_dly = adly; v.rdat = rdat;
        v.e_adr = eadr; v.e_dat = edat; v.e_we = ewe; v.e_len = elen; v.e_tx = etx;
        return v;
    endfunction

    vec_t vecs [6];

    initial begin
        int bus0, tx0;

        // write 12<-34, ack in 4th strobe cycle
        vecs[0] = mk(8'h77, 8'h12, 8'h34, 3, 1, 3,   8'h00, 8'h12, 8'h34, 1'b1, 4,   8'h2E);
        // read 05, immediate ack; write data register keeps 34
        vecs[1] = mk(8'h72, 8'h05, 8'h00, 2, 1, 0,   8'hA5, 8'h05, 8'h34, 1'b0, 1,   8'hA5);
        // junk opcode 41 dropped, then read 07
        vecs[2] = mk(8'h41, 8'h72, 8'h07, 3, 1, 1,   8'h3C, 8'h07, 8'h34, 1'b0, 2,   8'h3C);
        // read with no ack: full timeout, FF
        vecs[3] = mk(8'h72, 8'h09, 8'h00, 2, 0, 0,   8'h00, 8'h09, 8'h34, 1'b0, 255, 8'hFF);
        // write with no ack: NAK
        vecs[4] = mk(8'h77, 8'hAA, 8'h55, 3, 1, 999, 8'h00, 8'hAA, 8'h55, 1'b1, 255, 8'h21);
        // ack in the final permitted cycle still succeeds
        vecs[5] = mk(8'h77, 8'h80, 8'h01, 3, 1, 254, 8'h00, 8'h80, 8'h01, 1'b1, 255, 8'h2E);

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst address",  {31'd0, uart_address_o},     32'd1);
        check("rst wstrobe",  {31'd0, uart_writestrobe_o}, 32'd0);
        check("rst rstrobe",  {31'd0, uart_readstrobe_o},  32'd0);
        check("rst cyc/stb",  {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("rst we",       {31'd0, wb_we_o},            32'd0);
        check("rst adr/dat",  {16'd0, wb_adr_o, wb_dat_o}, 32'd0);
        check("rst uart_dat", {24'd0, uart_data_o},        32'd0);

        for (int i = 0; i < 6; i++) begin
            bus0    = n_bus;
            tx0     = n_tx;
            ack_en  = vecs[i].ack_en;
            ack_dly = vecs[i].ack_dly;
            rd_data = vecs[i].rdat;
            for (int j = 0; j < vecs[i].nb; j++) push(vecs[i].b[j]);
            wait_tx($sformatf("v%0d", i), tx0);
            repeat (4) @(negedge clk_i);
            check($sformatf("v%0d bus count", i), n_bus - bus0, 32'd1);
            check($sformatf("v%0d adr", i), {24'd0, cap_adr}, {24'd0, vecs[i].e_adr});
            check($sformatf("v%0d dat", i), {24'd0, cap_dat}, {24'd0, vecs[i].e_dat});
            check($sformatf("v%0d we", i),  {31'd0, cap_we},  {31'd0, vecs[i].e_we});
            check($sformatf("v%0d stb len", i), stb_len, vecs[i].e_len);
            check($sformatf("v%0d tx byte", i), {24'd0, last_tx}, {24'd0, vecs[i].e_tx});
            check($sformatf("v%0d tx count", i), n_tx - tx0, 32'd1);
            check($sformatf("v%0d rx drained", i), rx_wr - rx_rd, 32'd0);
        end

        // TX back-pressure: no strobe while tx_idle is low, then exactly one.
        tx0     = n_tx;
        tx_idle = 1'b0;
        ack_en  = 1'b1;
        ack_dly = 0;
        push(8'h77); push(8'h20); push(8'h30);
        repeat (100) @(negedge clk_i);
        check("txwait no strobe", n_tx - tx0, 32'd0);
        check("txwait cyc low", {31'd0, wb_cyc_o}, 32'd0);
        tx_idle = 1'b1;
        wait_tx("txwait", tx0);
        repeat (10) @(negedge clk_i);
        check("txwait one strobe", n_tx - tx0, 32'd1);
        check("txwait byte", {24'd0, last_tx}, 32'h2E);

        // Reset in the middle of a bus cycle.
        tx0    = n_tx;
        ack_en = 1'b0;
        push(8'h72); push(8'h11);
        begin
            int k;
            k = 0;
            while (!wb_stb_o && k < 200) begin
                @(negedge clk_i);
                k++;
            end
            check("midbus stb seen", {31'd0, wb_stb_o}, 32'd1);
        end
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midbus cyc/stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("midbus adr", {24'd0, wb_adr_o}, 32'd0);
        rst_i = 1'b0;
        repeat (300) @(negedge clk_i);
        check("midbus no tx", n_tx - tx0, 32'd0);
        bus0    = n_bus;
        ack_en  = 1'b1;
        ack_dly = 0;
        push(8'h77); push(8'h01); push(8'h02);
        wait_tx("post rst", tx0);
        repeat (4) @(negedge clk_i);
        check("post rst bus count", n_bus - bus0, 32'd1);
        check("post rst adr/dat", {16'd0, cap_adr, cap_dat}, 32'h0102);
        check("post rst we", {31'd0, cap_we}, 32'd1);
        check("post rst tx", {24'd0, last_tx}, 32'h2E);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
